// File: rtl/anti_theft_pkg.sv
// Shared definitions for the anti-theft time-parameter programming path:
// FSM state encoding, the command tag and the time-parameter table indices.
package anti_theft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_APPLY = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  // Upper two bits of every valid service-port command byte.
  localparam logic [1:0] CMD_TAG = 2'b10;

  // Table indices, same encoding as the time-parameter table's select input.
  localparam logic [1:0] PARAM_ARM_DELAY       = 2'b00;
  localparam logic [1:0] PARAM_DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] PARAM_PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] PARAM_ALARM_ON        = 2'b11;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchroniser, start/data/stop sampling, and
// single-cycle byte_valid / frame_err strobes on the stop-bit sample cycle.
module uart_rx_core
  import anti_theft_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       enable,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output state_t     state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic          sync1;
  logic          rx_s;
  logic          rx_s_d;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          stop_sample;

  assign stop_sample = (state == ST_STOP) && (baud_cnt == BIT_LAST);
  assign byte_valid  = stop_sample && rx_s;
  assign frame_err   = stop_sample && !rx_s;
  assign rx_byte     = shift;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b1;
      rx_s     <= 1'b1;
      rx_s_d   <= 1'b1;
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      sync1  <= rx;
      rx_s   <= sync1;
      rx_s_d <= rx_s;
      case (state)
        // Edges are only looked for while the wrapper is idle.
        ST_IDLE: begin
          if (enable && rx_s_d && !rx_s) begin
            state    <= ST_START;
            baud_cnt <= '0;
          end
        end
        ST_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/time_param_programmer.sv
// Service-port writer for the time-parameter table: decodes received UART
// bytes into sel/value writes and a reprogram strobe of PULSE_CYCLES cycles.
module time_param_programmer
  import anti_theft_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int PULSE_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [1:0] time_param_sel,
  output logic [3:0] time_value,
  output logic       reprogram,
  output logic       busy,
  output logic       cmd_ok,
  output logic       cmd_error,
  output state_t     dbg_state
);

  localparam int HW = $clog2(PULSE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(PULSE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  state_t        wr_state;
  state_t        rx_state;
  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          frame_err;
  logic          rx_enable;
  logic [HW-1:0] hold_cnt;

  assign rx_enable = (wr_state == ST_IDLE);
  assign busy      = (wr_state != ST_IDLE) || (rx_state != ST_IDLE);
  assign dbg_state = (wr_state != ST_IDLE) ? wr_state : rx_state;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .enable     (rx_enable),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .state      (rx_state)
  );

  // sel/value are registered on the APPLY edge, so they are settled by the
  // first cycle reprogram is seen high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state       <= ST_IDLE;
      hold_cnt       <= '0;
      time_param_sel <= '0;
      time_value     <= '0;
      reprogram      <= 1'b0;
      cmd_ok         <= 1'b0;
      cmd_error      <= 1'b0;
    end else begin
      cmd_ok    <= 1'b0;
      cmd_error <= 1'b0;
      case (wr_state)
        ST_IDLE: begin
          if (byte_valid)     wr_state  <= ST_APPLY;
          else if (frame_err) cmd_error <= 1'b1;
        end
        ST_APPLY: begin
          if (rx_byte[7:6] == CMD_TAG) begin
            time_param_sel <= rx_byte[5:4];
            time_value     <= rx_byte[3:0];
            reprogram      <= 1'b1;
            cmd_ok         <= 1'b1;
            hold_cnt       <= '0;
            wr_state       <= ST_HOLD;
          end else begin
            cmd_error <= 1'b1;
            wr_state  <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            reprogram <= 1'b0;
            wr_state  <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        default: wr_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_param_programmer.sv
// Bench for time_param_programmer: directed scenarios plus random frames,
// checked every cycle against a per-frame outcome model.
module tb_time_param_programmer;
  import anti_theft_pkg::*;

  localparam int CPB   = 16;
  localparam int PULSE = 3;
  localparam logic [1:0] K_OK  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       reprogram;
  logic       busy;
  logic       cmd_ok;
  logic       cmd_error;
  state_t     dbg_state;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int frame_start = 0;
  int ok_cyc = -1;
  int ok_count = 0;
  int err_count = 0;
  int rep_len = 0;
  int ok_before;
  int err_before;
  logic       prev_rep = 1'b0;
  logic [1:0] model_sel = '0;
  logic [3:0] model_val = '0;
  logic [7:0] exp_q[$];  // {kind, sel, val}
  logic [7:0] e_item;
  logic [7:0] rnd_b;
  logic       rnd_stop;

  time_param_programmer #(
    .CLKS_PER_BIT(CPB),
    .PULSE_CYCLES(PULSE)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rx             (rx),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .reprogram      (reprogram),
    .busy           (busy),
    .cmd_ok         (cmd_ok),
    .cmd_error      (cmd_error),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One 8N1 frame, LSB first. abort_bit >= 0 pulls reset mid data bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int abort_bit);
    if (abort_bit < 0) begin
      if (!stop_bit)               exp_q.push_back({K_ERR, 6'd0});
      else if (b[7:6] != CMD_TAG)  exp_q.push_back({K_ERR, 6'd0});
      else                         exp_q.push_back({K_OK, b[5:0]});
    end
    tick(1);
    frame_start = cyc;
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(CPB);
      rx = b[i];
      if (i == abort_bit) begin
        tick(CPB / 2);
        reset = 1'b0;
        rx    = 1'b1;
        return;
      end
    end
    tick(CPB);
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (!reset) begin
      model_sel = '0;
      model_val = '0;
      exp_q.delete();
      prev_rep = 1'b0;
      rep_len  = 0;
    end else begin
      check("ok_err_exclusive", {31'd0, cmd_ok & cmd_error}, 32'd0);
      check("ok_on_rep_rise", {31'd0, cmd_ok}, {31'd0, reprogram & ~prev_rep});
      if (reprogram) begin
        rep_len++;
        check("busy_in_hold", {31'd0, busy}, 32'd1);
      end else if (prev_rep) begin
        check("rep_width", rep_len, PULSE);
        rep_len = 0;
      end
      if (cmd_ok || cmd_error) begin
        if (cmd_ok) ok_count++;
        if (cmd_error) err_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, cmd_ok, cmd_error}, 32'd0);
        end else begin
          e_item = exp_q.pop_front();
          check("event_kind", {30'd0, cmd_ok, cmd_error},
                (e_item[7:6] == K_OK) ? 32'd2 : 32'd1);
          if (cmd_ok) begin
            model_sel = e_item[5:4];
            model_val = e_item[3:0];
            ok_cyc    = cyc;
          end
        end
      end
      check("sel", {30'd0, time_param_sel}, {30'd0, model_sel});
      check("val", {28'd0, time_value}, {28'd0, model_val});
      prev_rep = reprogram;
    end
  end

  initial begin
    tick(3);
    check("reset_outputs", {22'd0, time_param_sel, time_value, reprogram, busy, cmd_ok, cmd_error}, 32'd0);
    reset = 1'b1;
    tick(10);

    // 1: valid command, latency from start-bit drive to reprogram rise
    ok_before = ok_count;
    send_byte(8'h9A, 1'b1, -1);
    tick(8);
    check("t1_latency", ok_cyc - frame_start, 32'd156);
    check("t1_ok_count", ok_count - ok_before, 32'd1);
    check("t1_sel", {30'd0, time_param_sel}, 32'd1);
    check("t1_val", {28'd0, time_value}, 32'hA);

    // 2: bad tag
    err_before = err_count;
    send_byte(8'h3A, 1'b1, -1);
    tick(8);
    check("t2_err_count", err_count - err_before, 32'd1);
    check("t2_sel", {30'd0, time_param_sel}, 32'd1);
    check("t2_val", {28'd0, time_value}, 32'hA);

    // 3: framing error then the same byte framed correctly
    err_before = err_count;
    send_byte(8'hA5, 1'b0, -1);
    tick(8);
    check("t3_err_count", err_count - err_before, 32'd1);
    send_byte(8'hA5, 1'b1, -1);
    tick(8);
    check("t3_sel", {30'd0, time_param_sel}, 32'd2);
    check("t3_val", {28'd0, time_value}, 32'h5);

    // 4: short low glitch is dropped silently
    ok_before  = ok_count;
    err_before = err_count;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(20);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_events", (ok_count - ok_before) + (err_count - err_before), 32'd0);

    // 5: reset during data bit 4
    send_byte(8'h9F, 1'b1, 4);
    tick(1);
    check("t5_reset_outputs", {22'd0, time_param_sel, time_value, reprogram, busy, cmd_ok, cmd_error}, 32'd0);
    tick(3);
    reset = 1'b1;
    tick(40);
    send_byte(8'hBF, 1'b1, -1);
    tick(8);
    check("t5_sel", {30'd0, time_param_sel}, 32'd3);
    check("t5_val", {28'd0, time_value}, 32'hF);

    // 6: back-to-back with the minimum idle gap
    ok_before = ok_count;
    send_byte(8'h80, 1'b1, -1);
    tick(PULSE + 1);
    send_byte(8'h81, 1'b1, -1);
    tick(8);
    check("t6_ok_count", ok_count - ok_before, 32'd2);
    check("t6_sel", {30'd0, time_param_sel}, 32'd0);
    check("t6_val", {28'd0, time_value}, 32'h1);

    // line stuck low: exactly one framing error
    err_before = err_count;
    exp_q.push_back({K_ERR, 6'd0});
    rx = 1'b0;
    tick(400);
    rx = 1'b1;
    tick(10);
    check("stuck_low_errs", err_count - err_before, 32'd1);
    check("stuck_low_busy", {31'd0, busy}, 32'd0);

    // random frames
    for (int n = 0; n < 24; n++) begin
      rnd_b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) rnd_b[7:6] = CMD_TAG;
      rnd_stop = ($urandom_range(0, 5) != 0);
      send_byte(rnd_b, rnd_stop, -1);
      tick($urandom_range(PULSE + 1, 30));
    end
    tick(40);
    check("all_frames_resolved", exp_q.size(), 32'd0);
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
